// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared state encoding, sizes and round-robin pick helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan from ptr downward in priority so the smallest offset above ptr wins.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            r;
        logic [SEL_W-1:0] i;
        r = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            i = ptr + SEL_W'(k);
            if (req[i]) begin
                r.found = 1'b1;
                r.idx   = i;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_4x1.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1
// Description : One-bit 4-to-1 multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4x1 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] s,
    output logic       y
);

    always_comb begin
        case (s)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mux_4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_4x1_rr_arbiter
// Description : Round-robin arbiter sharing a 4:1 data path with beat-limited grants.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    input  logic [WIDTH-1:0] din_c,
    input  logic [WIDTH-1:0] din_d,
    output logic [3:0]       gnt,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int               c_cnt_w = $clog2(MAX_BEATS + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MAX_BEATS - 1);

    state_t                 r_state;
    logic [SEL_W-1:0]       r_ptr;
    logic [SEL_W-1:0]       r_s;
    logic [N_REQ-1:0]       r_gnt;
    logic [c_cnt_w-1:0]     r_beat_cnt;

    pick_t                  w_pick;
    logic                   w_req_s;
    logic                   w_beat;

    assign w_pick    = rr_pick(req, r_ptr);
    assign w_req_s   = req[r_s];
    assign out_valid = (r_state == GRANT) && w_req_s;
    assign w_beat    = out_valid && out_ready;
    assign gnt       = r_gnt;
    assign s         = r_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_s        <= '0;
            r_gnt      <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick.found) begin
                        r_s        <= w_pick.idx;
                        r_gnt      <= 4'b0001 << w_pick.idx;
                        r_beat_cnt <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    // A dropped request releases without a beat; s is kept for out_data.
                    if (!w_req_s || (w_beat && (r_beat_cnt == c_last))) begin
                        r_ptr   <= r_s + 2'd1;
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_4x1 u_mux (
            .a (din_a[i]),
            .b (din_b[i]),
            .c (din_c[i]),
            .d (din_d[i]),
            .s (r_s),
            .y (out_data[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4x1_rr_arbiter
// Description : Directed bench; two arbiters (4-beat and 1-beat) against a grant model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4x1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       out_ready = 1'b0;
    logic [7:0] din [4];

    logic [3:0] gnt0, gnt1;
    logic [1:0] s0, s1;
    logic [7:0] od0, od1;
    logic       ov0, ov1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: per arbiter, who owns the path, beats taken so far, and where the search starts.
    int mb    [2] = '{4, 1};
    int busy  [2] = '{0, 0};
    int own   [2] = '{0, 0};
    int taken [2] = '{0, 0};
    int ptr   [2] = '{0, 0};
    int sel   [2] = '{0, 0};
    int nbeats[2] = '{0, 0};
    int sig   [2] = '{0, 0};

    always #5 clk = ~clk;

    mux_4x1_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din_a(din[0]), .din_b(din[1]), .din_c(din[2]), .din_d(din[3]),
        .gnt(gnt0), .s(s0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready)
    );

    mux_4x1_rr_arbiter #(.WIDTH(8), .MAX_BEATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din_a(din[0]), .din_b(din[1]), .din_c(din[2]), .din_d(din[3]),
        .gnt(gnt1), .s(s1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        if (busy[d] == 0) begin
            for (int k = 0; k < 4; k++) begin
                if (busy[d] == 0 && req[(ptr[d] + k) % 4]) begin
                    busy[d]  = 1;
                    own[d]   = (ptr[d] + k) % 4;
                    sel[d]   = own[d];
                    taken[d] = 0;
                    sig[d]   = sig[d] * 8 + own[d] + 1;
                end
            end
        end else if (!req[own[d]]) begin
            busy[d] = 0;
            ptr[d]  = (own[d] + 1) % 4;
        end else if (out_ready) begin
            nbeats[d]++;
            taken[d]++;
            if (taken[d] == mb[d]) begin
                busy[d] = 0;
                ptr[d]  = (own[d] + 1) % 4;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    busy[d] = 0; own[d] = 0; taken[d] = 0; ptr[d] = 0; sel[d] = 0;
                end else begin
                    model_step(d);
                end
            end
        end
    end

    task automatic cmp(input int d, input logic [3:0] g, input logic [1:0] sv,
                       input logic v, input logic [7:0] od);
        int eg, ev;
        eg = busy[d] ? (1 << own[d]) : 0;
        ev = (busy[d] && req[own[d]]) ? 1 : 0;
        chk($sformatf("dut%0d_gnt", d), int'(g), eg);
        chk($sformatf("dut%0d_s", d), int'(sv), sel[d]);
        chk($sformatf("dut%0d_out_valid", d), int'(v), ev);
        chk($sformatf("dut%0d_out_data", d), int'(od), int'(din[sel[d]]));
    endtask

    always @(negedge clk) begin
        cmp(0, gnt0, s0, ov0, od0);
        cmp(1, gnt1, s1, ov1, od1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic restart();
        req = 4'b0000;
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            nbeats[d] = 0;
            sig[d]    = 0;
        end
    endtask

    initial begin
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
        tick(2);
        chk("reset_gnt", int'(gnt0), 0);
        chk("reset_out_valid", int'(ov0), 0);
        chk("reset_s", int'(s0), 0);
        rst_n = 1'b1;

        // Single requester, long stream
        restart();
        din[2] = 8'hA5;
        req = 4'b0100; out_ready = 1'b1;
        tick(2);
        chk("single_gnt", int'(gnt0), 4);
        chk("single_s", int'(s0), 2);
        tick(8);
        chk("single_beats", nbeats[0], 8);
        chk("single_order", sig[0], 'o33);

        // Round robin from reset, all requesting
        restart();
        req = 4'b1111; out_ready = 1'b1;
        tick(25);
        chk("rr_order", sig[0], 'o12341);
        chk("rr_beats", nbeats[0], 20);

        // Early drop by requester 1 after two beats
        restart();
        req = 4'b0010; out_ready = 1'b1;
        tick(3);
        req = 4'b1001;
        tick(2);
        chk("drop_order", sig[0], 'o24);
        chk("drop_beats", nbeats[0], 2);
        chk("drop_gnt", int'(gnt0), 8);

        // Backpressure on requester 3
        restart();
        din[3] = 8'h5A;
        req = 4'b1000; out_ready = 1'b0;
        tick(6);
        chk("stall_valid", int'(ov0), 1);
        chk("stall_data", int'(od0), 8'h5A);
        chk("stall_beats", nbeats[0], 0);
        out_ready = 1'b1;
        tick(4);
        chk("stall_after_beats", nbeats[0], 4);
        chk("stall_released", int'(gnt0), 0);
        req = 4'b1001;
        tick(1);
        chk("stall_wrap_gnt", int'(gnt0), 1);

        // Reset during the second beat
        restart();
        req = 4'b0100; out_ready = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_gnt", int'(gnt0), 0);
        chk("rst_mid_valid", int'(ov0), 0);
        chk("rst_mid_s", int'(s0), 0);
        tick(1);
        rst_n = 1'b1;
        req = 4'b1000;
        tick(1);
        chk("rst_after_gnt", int'(gnt0), 8);
        chk("rst_after_s", int'(s0), 3);

        // Single-beat grants alternate between two requesters
        restart();
        req = 4'b0011; out_ready = 1'b1;
        tick(8);
        chk("mb1_order", sig[1], 'o1212);
        chk("mb1_beats", nbeats[1], 4);

        req = 4'b0000;
        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
